demux_1_2_buf: RTL and testbench

- Registered 1-to-2 demultiplexer. It is the fan-out counterpart of the 2:1 operand selectors in the 16-bit CLA datapath.
- It steers one valid/ready word stream to one of two consumer channels, for example operand A/B staging for the adder.
- Each output channel has its own small FIFO, so one stalled consumer does not block traffic bound for the other channel.

---
 rtl/demux_1_2_buf.sv | 80 ++++++++
 tb/tb_demux_1_2_buf.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/demux_1_2_buf.sv
// Registered 1-to-2 demultiplexer: one valid/ready word stream is steered by
// in_sel into one of two independent FIFOs, so a stalled consumer on one
// channel never blocks words bound for the other channel.
module demux_1_2_buf #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            full;
  logic [1:0]            valid;
  logic [1:0]            ready;
  logic [1:0][WIDTH-1:0] head;
  logic                  accept;

  assign ready = {out1_ready, out0_ready};

  // Input handshake: only the addressed channel's full flag matters.
  always_comb begin
    in_ready = !rst && (in_sel ? !full[1] : !full[0]);
    accept   = in_valid && in_ready;
    push     = '0;
    push[0]  = accept && !in_sel;
    push[1]  = accept && in_sel;
    pop      = valid & ready;
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // Per-channel FIFO state: storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem    <= '{default: '0};
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[g]) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop[g]) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        cnt <= cnt + CW'(push[g]) - CW'(pop[g]);
      end
    end

    assign full[g]  = (cnt == CW'(DEPTH));
    assign valid[g] = (cnt != '0);
    assign head[g]  = mem[rd_ptr];
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];

endmodule

// File: tb/tb_demux_1_2_buf.sv
// Bench for demux_1_2_buf: directed scenarios followed by a random phase,
// all checked against a per-channel queue model of the buffered words.
module tb_demux_1_2_buf;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sel = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out0_valid;
  logic             out0_ready = 1'b0;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready = 1'b0;
  logic [WIDTH-1:0] out1_data;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];

  demux_1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the queues,
  // then apply the cycle's push/pop to the queues at the rising edge.
  task automatic cyc(input logic v, input logic s, input logic [WIDTH-1:0] d,
                     input logic r0, input logic r1, output logic acc);
    logic exp_rdy;
    logic p0;
    logic p1;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("in_ready", in_ready, exp_rdy);
    chk("out0_valid", out0_valid, q0.size() != 0);
    chk("out1_valid", out1_valid, q1.size() != 0);
    if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
    acc = v && exp_rdy;
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    @(negedge clk);
  endtask

  logic             a;
  logic             hv;
  logic             hs;
  logic [WIDTH-1:0] hd;

  initial begin
    // Reset then idle, with a mid-cycle reset pulse.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out0_valid", out0_valid, 1'b0);
    chk("rst_out1_valid", out1_valid, 1'b0);
    chk("rst_out0_data", out0_data, '0);
    chk("rst_out1_data", out1_data, '0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, a);

    // Single route to channel 0.
    cyc(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, a);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, a);

    // Fill channel 0 and check backpressure is per channel.
    cyc(1'b1, 1'b0, 16'hA001, 1'b0, 1'b0, a);
    cyc(1'b1, 1'b0, 16'hA002, 1'b0, 1'b0, a);
    cyc(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0, a);
    chk("full_ch0_blocked", a, 1'b0);
    cyc(1'b1, 1'b1, 16'hB001, 1'b0, 1'b0, a);
    chk("ch1_accepted", a, 1'b1);

    // Drain channel 0 in order, then stream through the pointer wrap.
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'hC000 + 16'(i), 1'b1, 1'b0, a);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, a);

    // Push and pop at count 1 on channel 1.
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b1, a);
    cyc(1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0, a);
    cyc(1'b1, 1'b1, 16'h00FF, 1'b0, 1'b1, a);
    chk("ch1_count1_head", out1_data, 16'h00FF);
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b0, a);

    // Reset mid-operation with both channels holding words.
    cyc(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, a);
    cyc(1'b1, 1'b1, 16'h6666, 1'b0, 1'b0, a);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out0_valid", out0_valid, 1'b0);
    chk("midrst_out1_valid", out1_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'(i), '0, 1'b1, 1'b1, a);

    // Random traffic; a stalled word keeps its data and destination.
    hv = 1'b0;
    hs = 1'b0;
    hd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 3) != 0);
        hs = 1'($urandom);
        hd = WIDTH'($urandom);
      end
      cyc(hv, hs, hd, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), a);
      if (a || !hv) hv = 1'b0;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
